sram_access_arbiter: RTL
========================

# sram_access_arbiter

Arbitrates the single external SRAM port among the three decompressor stages: decode (M3), IDCT (M2) and upsample/colourspace conversion (M1). It replaces hard-wired, state-driven muxing with a request/grant handshake, so stages can overlap their SRAM phases safely. It sits between the stage controllers and the SRAM controller. It inserts a read-drain gap on every ownership change, so in-flight read data is never attributed to the wrong owner.

## Interface
Parameters:
- READ_LATENCY, 2, SRAM read latency in cycles; length of the drain gap; legal range 1..7
- MAX_HOLD, 0, maximum consecutive granted cycles before forced release when another request is pending; 0 = unlimited
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (index 0 highest)

Ports:
- Clock  in  1  system clock
- Resetn  in  1  asynchronous, active-low reset
- Req  in  3  per-requester request; index 0 decode, 1 IDCT, 2 UCSC
- Req_address  in  3x18  per-requester SRAM address
- Req_write_data  in  3x16  per-requester SRAM write data
- Req_we_n  in  3  per-requester active-low write enable
- Grant  out  3  one-hot-or-zero grant, registered
- Owner  out  2  index of current owner; 2'd3 when no owner
- Busy  out  1  high in GRANTED or DRAIN
- SRAM_address  out  18  muxed address to SRAM controller
- SRAM_write_data  out  16  muxed write data
- SRAM_we_n  out  1  muxed active-low write enable

## Operation
- States: IDLE, GRANTED, DRAIN.
- Reset values:
  - State is IDLE, Grant = 0, Owner = 3, Busy = 0.
  - SRAM outputs are idle: address 0, data 0, we_n = 1.
  - The round-robin pointer is 2, so requester 0 wins first.
  - The hold counter is 0.
- SRAM outputs:
  - In GRANTED, the owner's bundle drives the SRAM outputs combinationally.
  - In IDLE and DRAIN, the SRAM outputs carry the idle values.
- IDLE:
  - If any Req bit is high, select a winner and go to GRANTED.
  - The winner's Grant bit and Owner are registered on the same edge.
- Winner selection:
  - RR_MODE = 1: the first requesting index after the last owner, modulo 3.
  - RR_MODE = 0: the lowest requesting index.
- GRANTED:
  - The hold counter increments each cycle and saturates at 255.
  - If Req[Owner] goes low, go to DRAIN.
  - If MAX_HOLD ≠ 0, the counter equals MAX_HOLD and any other Req bit is high, go to DRAIN (preemption).
  - On entering DRAIN, clear Grant, set Owner = 3 and update the round-robin pointer to the departing owner.
  - A preempted requester keeps Req high and competes again normally.
- DRAIN:
  - Counts READ_LATENCY cycles with SRAM outputs idle.
  - On the last cycle, arbitrate as in IDLE. Go to GRANTED if any Req bit is high, otherwise go to IDLE.
- Requester obligations:
  - A requester drives its bundle and consumes SRAM_read_data only while its Grant bit is high, plus READ_LATENCY cycles after the edge where Grant falls.
  - Req changes from non-owners during GRANTED or DRAIN are sampled only at arbitration points.
- Grant is never one-hot to two requesters at once. Violations are checked by an assertion.

## Timing
- Grant latency from IDLE: Req[i] rises at edge t; Grant[i] is high from t+1, and its bundle reaches SRAM in the same cycle.
- Release: Req[owner] low at t; Grant falls at t+1. DRAIN covers cycles t+1 .. t+READ_LATENCY; the next Grant is possible at t+READ_LATENCY+1.
- Preemption: the hold counter reaches MAX_HOLD at cycle t with a competitor pending; Grant falls at t+1 with the same drain timing as a release.
- Owner drops Req in its first granted cycle: treated as a normal release, with the full drain applied.
- Simultaneous requests in IDLE: exactly one wins per the selection policy; the others wait with Grant low.
- Reset mid-grant: Grant clears and SRAM_we_n goes high asynchronously. No drain is performed, and in-flight reads are discarded.

## Structure
- Package `sram_arb_pkg`:
  - `sram_arb_state_type` enum (IDLE, GRANTED, DRAIN).
  - Constants REQ_DECODE = 0, REQ_IDCT = 1, REQ_UCSC = 2, NO_OWNER = 2'd3.
- Sub-module `rr_priority_select`: a combinational winner picker (Req, last pointer, mode → valid, index). It is reused by any future multi-requester arbiter.
- The top level holds the FSM, drain counter, hold counter, round-robin pointer and output mux.

## Test plan
- Single request, RR_MODE=1, READ_LATENCY=2: Req=001 at t → Grant=001 at t+1 and SRAM_address equals Req_address[0]. Req=000 at t+5 → Grant=000 at t+6, SRAM_we_n=1 for t+6..t+7.
- Round-robin fairness: Req=111 held constantly, each owner releases after 4 cycles → grant order 0,1,2,0, with exactly 2 idle cycles between grants.
- Fixed priority, RR_MODE=0: Req=110 then Req=111 during the drain → next Grant=001, not 100.
- Preemption with MAX_HOLD=8: Req[1] held, Req[2] rises at cycle 3 of the grant → Grant[1] falls after the 8th granted cycle; Grant[2]=1 follows READ_LATENCY cycles later.
- Immediate release: owner drops Req on its first granted cycle → still one grant cycle followed by the full drain; no other Grant overlaps.
- Resetn pulsed low mid-GRANTED while the owner is writing → Grant=000, SRAM_we_n=1, Owner=3 before the next edge; after release, Req=100 → Grant=100 one cycle later.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter and related arbiters.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    DRAIN   = 2'd2
  } sram_arb_state_type;

  // Requester indices and the "nobody owns the port" marker
  localparam logic [1:0] REQ_DECODE = 2'd0;
  localparam logic [1:0] REQ_IDCT   = 2'd1;
  localparam logic [1:0] REQ_UCSC   = 2'd2;
  localparam logic [1:0] NO_OWNER   = 2'd3;

  // Next requester index in round-robin order, wrapping 2 -> 0
  function automatic logic [1:0] next_index(input logic [1:0] idx);
    return (idx >= REQ_UCSC) ? REQ_DECODE : idx + 2'd1;
  endfunction

  // One-hot grant vector for a requester index; NO_OWNER maps to all-zero
  function automatic logic [2:0] grant_onehot(input logic [1:0] idx);
    case (idx)
      REQ_DECODE: return 3'b001;
      REQ_IDCT:   return 3'b010;
      REQ_UCSC:   return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational winner picker for three requesters: round-robin starting
// after the last owner, or fixed priority with index 0 highest.
module rr_priority_select
  import sram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic       rr_mode,
  output logic       valid,
  output logic [1:0] index
);

  logic [1:0] cand_first;
  logic [1:0] cand_second;
  logic [1:0] cand_third;

  assign cand_first  = next_index(last);
  assign cand_second = next_index(cand_first);
  assign cand_third  = next_index(cand_second);

  // Pick the winner; later assignments override earlier, so the highest
  // priority candidate is tested last
  always_comb begin
    valid = |req;
    index = NO_OWNER;
    if (rr_mode) begin
      if (req[cand_third])  index = cand_third;
      if (req[cand_second]) index = cand_second;
      if (req[cand_first])  index = cand_first;
    end else begin
      if (req[REQ_UCSC])   index = REQ_UCSC;
      if (req[REQ_IDCT])   index = REQ_IDCT;
      if (req[REQ_DECODE]) index = REQ_DECODE;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Request/grant arbiter for the shared external SRAM port. Every ownership
// change passes through a READ_LATENCY-cycle drain with the SRAM port idle so
// in-flight read data is never attributed to the wrong stage.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MAX_HOLD     = 0,
  parameter int RR_MODE      = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [2:0]  Req,
  input  logic [53:0] Req_address,
  input  logic [47:0] Req_write_data,
  input  logic [2:0]  Req_we_n,
  output logic [2:0]  Grant,
  output logic [1:0]  Owner,
  output logic        Busy,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  localparam logic [2:0] DRAIN_INIT = 3'(READ_LATENCY - 1);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic       RR_EN      = (RR_MODE != 0);

  sram_arb_state_type state_reg;
  logic [1:0]         rr_ptr_reg;
  logic [7:0]         hold_cnt_reg;
  logic [2:0]         drain_cnt_reg;

  logic               sel_valid;
  logic [1:0]         sel_index;
  logic               owner_req;
  logic               preempt;

  // Per-requester bundles; slot 3 holds the idle values so Owner = NO_OWNER
  // indexes a safe entry
  logic [17:0] addr_arr [4];
  logic [15:0] data_arr [4];
  logic        we_arr   [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_bundle
    if (gi < 3) begin : g_req
      assign addr_arr[gi] = Req_address[gi*18 +: 18];
      assign data_arr[gi] = Req_write_data[gi*16 +: 16];
      assign we_arr[gi]   = Req_we_n[gi];
    end else begin : g_idle
      assign addr_arr[gi] = '0;
      assign data_arr[gi] = '0;
      assign we_arr[gi]   = 1'b1;
    end
  end

  rr_priority_select u_select (
    .req     (Req),
    .last    (rr_ptr_reg),
    .rr_mode (RR_EN),
    .valid   (sel_valid),
    .index   (sel_index)
  );

  assign owner_req = |(Req & Grant);
  assign preempt   = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT) && (|(Req & ~Grant));

  // Arbitration FSM with registered Grant/Owner/Busy and the hold/drain counters
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      Grant         <= 3'b000;
      Owner         <= NO_OWNER;
      Busy          <= 1'b0;
      rr_ptr_reg    <= REQ_UCSC;
      hold_cnt_reg  <= 8'd0;
      drain_cnt_reg <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_valid) begin
            state_reg    <= GRANTED;
            Grant        <= grant_onehot(sel_index);
            Owner        <= sel_index;
            Busy         <= 1'b1;
            hold_cnt_reg <= 8'd1;
          end
        end
        GRANTED: begin
          if (!owner_req || preempt) begin
            state_reg     <= DRAIN;
            Grant         <= 3'b000;
            Owner         <= NO_OWNER;
            rr_ptr_reg    <= Owner;
            drain_cnt_reg <= DRAIN_INIT;
          end else if (hold_cnt_reg != 8'hFF) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg != 3'd0) begin
            drain_cnt_reg <= drain_cnt_reg - 3'd1;
          end else if (sel_valid) begin
            state_reg    <= GRANTED;
            Grant        <= grant_onehot(sel_index);
            Owner        <= sel_index;
            hold_cnt_reg <= 8'd1;
          end else begin
            state_reg <= IDLE;
            Busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          Grant     <= 3'b000;
          Owner     <= NO_OWNER;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

  // Route the owner's bundle to the SRAM only while granted; idle values otherwise
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    if (state_reg == GRANTED) begin
      SRAM_address    = addr_arr[Owner];
      SRAM_write_data = data_arr[Owner];
      SRAM_we_n       = we_arr[Owner];
    end
  end

  // Grant must never select more than one requester
  always @(posedge Clock) begin
    if (Resetn) begin
      assert ($onehot0(Grant));
    end
  end

endmodule
